// File: rtl/comma_aligner_20b_if.sv
// rtl/comma_aligner_20b_if.sv - raw word in, aligned word and lock status out
// master drives the deserializer side; slave is the aligner.
interface comma_aligner_20b_if;
  logic [19:0] din;
  logic        din_en;
  logic        comma_detected;
  logic [19:0] aligned_data;
  logic [1:0]  fsm_state;
  logic        align_acquired;

  modport master (
    output din,
    output din_en,
    input  comma_detected,
    input  aligned_data,
    input  fsm_state,
    input  align_acquired
  );

  modport slave (
    input  din,
    input  din_en,
    output comma_detected,
    output aligned_data,
    output fsm_state,
    output align_acquired
  );
endinterface

// File: rtl/comma_aligner_20b.sv
// rtl/comma_aligner_20b.sv - K28.5 comma search and word-boundary lock for a 20-bit 8b10b lane
// Output words carry two whole code groups with the comma-bearing group in [19:10].
module comma_aligner_20b (
  input  logic                       clock_pcs,
  input  logic                       reset,
  comma_aligner_20b_if.slave         bus
);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_CHECK   = 2'd1,
    S_LOCKED  = 2'd2,
    S_ILLEGAL = 2'd3
  } state_t;

  localparam logic [6:0] COMMA_NEG = 7'b0011111;
  localparam logic [6:0] COMMA_POS = 7'b1100000;

  state_t      state_q, state_d;
  logic [19:0] prev_q;
  logic [4:0]  offset_q, offset_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        comma_q;
  logic [19:0] aligned_q, aligned_d;
  logic        acquired_q;

  logic [39:0] win;
  logic [39:0] win_shifted;
  logic [19:0] match;
  logic        any_match;
  logic        offset_hit;
  logic [4:0]  pmin;

  assign win = {prev_q, bus.din};

  // Candidate p looks at the 7 bits starting p bits after the oldest bit of the window.
  always_comb begin
    match = '0;
    for (int p = 0; p < 20; p++) begin
      match[p] = (win[39-p -: 7] == COMMA_NEG) || (win[39-p -: 7] == COMMA_POS);
    end
  end

  always_comb begin
    pmin = 5'd0;
    for (int p = 19; p >= 0; p--) begin
      if (match[p]) pmin = 5'(p);
    end
  end

  assign any_match  = |match;
  assign offset_hit = match[offset_q];

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_SEARCH: begin
        if (any_match) begin
          offset_d = pmin;
          cnt_d    = 2'd1;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (offset_hit) begin
          if (cnt_q + 2'd1 == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = S_LOCKED;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (any_match) begin
          offset_d = pmin;
          cnt_d    = 2'd1;
        end
      end
      S_LOCKED: begin
        if (offset_hit) begin
          cnt_d = 2'd0;
        end else if (any_match) begin
          // cnt already holds three misses: this is the fourth in a row.
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = S_SEARCH;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = S_SEARCH;
      end
    endcase
  end

  // Slice(p) = win[39-p -: 20], taken at the offset chosen this cycle.
  assign win_shifted = win >> (6'd20 - {1'b0, offset_d});
  assign aligned_d   = win_shifted[19:0];

  always_ff @(posedge clock_pcs) begin
    if (reset) begin
      state_q    <= S_SEARCH;
      prev_q     <= '0;
      offset_q   <= '0;
      cnt_q      <= '0;
      comma_q    <= 1'b0;
      aligned_q  <= '0;
      acquired_q <= 1'b0;
    end else if (bus.din_en) begin
      state_q    <= state_d;
      prev_q     <= bus.din;
      offset_q   <= offset_d;
      cnt_q      <= cnt_d;
      comma_q    <= any_match;
      aligned_q  <= aligned_d;
      acquired_q <= (state_d == S_LOCKED);
    end else begin
      comma_q    <= 1'b0;
    end
  end

  assign bus.comma_detected = comma_q;
  assign bus.aligned_data   = aligned_q;
  assign bus.fsm_state      = state_q;
  assign bus.align_acquired = acquired_q;

endmodule

// File: tb/tb_comma_aligner_20b.sv
// tb/tb_comma_aligner_20b.sv - directed bench for comma_aligner_20b
// Hand-computed expectations for reset, lock, slip, loss of lock, stall and non-comma data.
module tb_comma_aligner_20b;

  logic clock_pcs;
  logic reset;
  int   checks;
  int   errors;

  comma_aligner_20b_if bus ();

  comma_aligner_20b dut (
    .clock_pcs (clock_pcs),
    .reset     (reset),
    .bus       (bus)
  );

  initial clock_pcs = 1'b0;
  always #5 clock_pcs = ~clock_pcs;

  localparam logic [19:0] W_ALN  = 20'h3EB05;
  localparam logic [19:0] W_SLIP = 20'hA7D60;

  task automatic step(input logic rst, input logic en, input logic [19:0] d);
    @(negedge clock_pcs);
    reset      = rst;
    bus.din_en = en;
    bus.din    = d;
    @(posedge clock_pcs);
    #1;
  endtask

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic cd, input logic [1:0] st,
                         input logic acq, input logic [19:0] ad);
    chk({tag, ".comma_detected"}, {19'd0, bus.comma_detected}, {19'd0, cd});
    chk({tag, ".fsm_state"},      {18'd0, bus.fsm_state},      {18'd0, st});
    chk({tag, ".align_acquired"}, {19'd0, bus.align_acquired}, {19'd0, acq});
    chk({tag, ".aligned_data"},   bus.aligned_data,            ad);
  endtask

  logic [1:0]  exp_st  [6];
  logic [19:0] exp_ad  [6];
  logic [19:0] nc_data [5];

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    bus.din_en = 1'b0;
    bus.din    = '0;

    // Reset held with toggling input
    step(1'b1, 1'b1, W_ALN);
    step(1'b1, 1'b1, W_SLIP);
    step(1'b1, 1'b1, 20'hFFFFF);
    chk_out("reset", 1'b0, 2'd0, 1'b0, 20'h00000);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, W_ALN);
      chk_out($sformatf("idle%0d", i), 1'b0, 2'd0, 1'b0, 20'h00000);
    end

    // Aligned comma stream
    exp_st = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    exp_ad = '{20'h00000, W_ALN, W_ALN, W_ALN, W_ALN, W_ALN};
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, W_ALN);
      chk_out($sformatf("aln%0d", i + 1), (i != 0), exp_st[i], (exp_st[i] == 2'd2), exp_ad[i]);
    end

    // Same bitstream slipped by 3 bits
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, W_SLIP);
      chk_out($sformatf("slip%0d", i + 1), (i != 0), exp_st[i], (exp_st[i] == 2'd2), exp_ad[i]);
    end

    // Loss of lock: locked at offset 0, then the stream slips
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, W_ALN);
    chk_out("lol.locked", 1'b1, 2'd2, 1'b1, W_ALN);
    // The first slipped word still shows the old comma at offset 0 (prev is aligned)
    step(1'b0, 1'b1, W_SLIP);
    chk_out("lol.w1", 1'b1, 2'd2, 1'b1, W_ALN);
    for (int i = 2; i <= 4; i++) begin
      step(1'b0, 1'b1, W_SLIP);
      chk_out($sformatf("lol.w%0d", i), 1'b1, 2'd2, 1'b1, W_SLIP);
    end
    step(1'b0, 1'b1, W_SLIP);
    chk_out("lol.w5", 1'b1, 2'd0, 1'b0, W_SLIP);
    step(1'b0, 1'b1, W_SLIP);
    chk_out("lol.recheck", 1'b1, 2'd1, 1'b0, W_ALN);

    // Mid-lock reset
    step(1'b1, 1'b1, W_SLIP);
    chk_out("midreset", 1'b0, 2'd0, 1'b0, 20'h00000);

    // Stall during lock; the window must not advance on the garbage din
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, W_ALN);
    chk_out("stall.locked", 1'b1, 2'd2, 1'b1, W_ALN);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, W_SLIP);
      chk_out($sformatf("stall%0d", i), 1'b0, 2'd2, 1'b1, W_ALN);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, W_ALN);
      chk_out($sformatf("resume%0d", i), 1'b1, 2'd2, 1'b1, W_ALN);
    end

    // Non-comma data passes through delayed by one word
    nc_data = '{20'h00000, 20'h00000, 20'h55555, 20'hAAAAA, 20'h55555};
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, nc_data[i]);
      chk_out($sformatf("nc%0d", i), 1'b0, 2'd0, 1'b0, (i == 0) ? 20'h00000 : nc_data[i-1]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
